// File: rtl/barrel_cmd_sequencer.sv
// Command FIFO plus LOAD/SHIFT/DONE sequencer driving the barrel rotator's Load, Select and Data_in.
// Optional Abort input is compiled in when SEQ_ABORT_EN is defined.

module barrel_cmd_sequencer #(
    parameter int DATA_SIZE  = 8,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Cmd_valid,
    output logic                          Cmd_ready,
    input  logic [DATA_SIZE-1:0]          Cmd_data,
    input  logic [SEL_W-1:0]              Cmd_select,
    input  logic [CNT_W-1:0]              Cmd_steps,
`ifdef SEQ_ABORT_EN
    input  logic                          Abort,
`endif
    output logic                          Load,
    output logic [SEL_W-1:0]              Select,
    output logic [DATA_SIZE-1:0]          Data_out,
    output logic                          Busy,
    output logic                          Done,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic [SEL_W-1:0]     sel;
        logic [CNT_W-1:0]     steps;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    cmd_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    state_t           state_q;
    state_t           state_d;
    cmd_t             cmd_q;
    logic [CNT_W-1:0] step_q;
    logic             push;
    logic             pop;
    logic             abort_req;

`ifdef SEQ_ABORT_EN
    assign abort_req = Abort;
`else
    assign abort_req = 1'b0;
`endif

    assign Cmd_ready  = (count_q != FULL_CNT);
    assign push       = Cmd_valid && Cmd_ready;
    assign Fifo_count = count_q;
    // The command register doubles as the held Select/Data_out drive, so both persist through IDLE.
    assign Data_out   = cmd_q.data;
    assign Select     = cmd_q.sel;

    always_comb begin
        // NOTE: defaults first so every path assigns state_d and pop; no latch can be inferred.
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (cmd_q.steps == '0) ? S_DONE : S_SHIFT;
                if (abort_req) state_d = S_DONE;
            end
            S_SHIFT: begin
                if (step_q == CNT_W'(1) || abort_req) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: FIFO storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= {Cmd_data, Cmd_select, Cmd_steps};
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            state_q <= S_IDLE;
            cmd_q   <= '0;
            step_q  <= '0;
            Load    <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: ;
            endcase

            state_q <= state_d;
            if (pop) cmd_q <= mem[rd_ptr];

            if (state_q == S_LOAD)       step_q <= cmd_q.steps;
            else if (state_q == S_SHIFT) step_q <= step_q - CNT_W'(1);

            // Outputs are registered from the next state so they line up with the state they describe.
            Load <= (state_d == S_LOAD);
            Busy <= (state_d != S_IDLE);
            Done <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_barrel_cmd_sequencer.sv
// Scoreboard bench for barrel_cmd_sequencer: a driver queues expected commands, a monitor checks each cycle.
// Abort stimulus is included when SEQ_ABORT_EN is defined.

module tb_barrel_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Cmd_valid;
    logic       Cmd_ready;
    logic [7:0] Cmd_data;
    logic [2:0] Cmd_select;
    logic [3:0] Cmd_steps;
    logic       Load;
    logic [2:0] Select;
    logic [7:0] Data_out;
    logic       Busy;
    logic       Done;
    logic [2:0] Fifo_count;
`ifdef SEQ_ABORT_EN
    logic       abort_in;
`endif

    barrel_cmd_sequencer #(
        .DATA_SIZE(8), .SEL_W(3), .CNT_W(4), .FIFO_DEPTH(DEPTH)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Cmd_valid(Cmd_valid),
        .Cmd_ready(Cmd_ready),
        .Cmd_data(Cmd_data),
        .Cmd_select(Cmd_select),
        .Cmd_steps(Cmd_steps),
`ifdef SEQ_ABORT_EN
        .Abort(abort_in),
`endif
        .Load(Load),
        .Select(Select),
        .Data_out(Data_out),
        .Busy(Busy),
        .Done(Done),
        .Fifo_count(Fifo_count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] data;
        logic [2:0] sel;
        logic [3:0] steps;
        int         exp_shifts;
    } exp_cmd_t;

    // Commands accepted but not yet seen on Load, in push order.
    exp_cmd_t exp_q[$];
    exp_cmd_t cur;
    bit       in_cmd;
    int       shift_cnt;
    int       cyc;
    int       done_cyc;
    bit       pend_at_done;
    logic [7:0] last_data;
    logic [2:0] last_sel;

    int total = 0;
    int bad   = 0;
    bit stall_seen;
    int peak_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: the sequencer's observable contract, one command at a time.
    always @(negedge Clock) begin
        cyc++;
        if (Reset) begin
            exp_q.delete();
            in_cmd       = 1'b0;
            pend_at_done = 1'b0;
            last_data    = '0;
            last_sel     = '0;
        end else begin
            if (Load) begin
                check("done_during_load", Done, 1'b0);
                if (exp_q.size() == 0) begin
                    fail("unexpected_load");
                end else begin
                    cur = exp_q.pop_front();
                    if (pend_at_done) check("load_spacing", cyc - done_cyc, 2);
                    pend_at_done = 1'b0;
                    in_cmd       = 1'b1;
                    shift_cnt    = 0;
                    last_data    = cur.data;
                    last_sel     = cur.sel;
                end
            end else if (Done) begin
                if (!in_cmd) begin
                    fail("spurious_done");
                end else begin
                    check("shift_cycles", shift_cnt, cur.exp_shifts);
                    in_cmd       = 1'b0;
                    done_cyc     = cyc;
                    pend_at_done = (exp_q.size() != 0);
                end
            end else if (in_cmd) begin
                shift_cnt++;
            end
            check("data_out", Data_out, last_data);
            check("select", Select, last_sel);
            check("busy", Busy, Load || Done || in_cmd);
            check("fifo_count", Fifo_count, exp_q.size());
            check("cmd_ready", Cmd_ready, exp_q.size() != DEPTH);
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic push_cmd(input logic [7:0] d, input logic [2:0] s, input logic [3:0] n,
                            input int exp_sh);
        bit accepted = 1'b0;
        int waited   = 0;
        Cmd_valid  = 1'b1;
        Cmd_data   = d;
        Cmd_select = s;
        Cmd_steps  = n;
        while (!accepted && waited < 1000) begin
            #1;
            accepted = Cmd_ready && !Reset;
            if (!Cmd_ready) stall_seen = 1'b1;
            if (int'(Fifo_count) > peak_count) peak_count = int'(Fifo_count);
            @(posedge Clock);
            #1;
            waited++;
        end
        if (accepted) exp_q.push_back('{data: d, sel: s, steps: n, exp_shifts: exp_sh});
        else fail("push_timeout");
        Cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || in_cmd) && waited < 2000) begin
            @(posedge Clock);
            #1;
            waited++;
        end
        if (exp_q.size() != 0 || in_cmd) fail("drain_timeout");
        repeat (2) @(posedge Clock);
        #1;
    endtask

    task automatic wait_load();
        int waited = 0;
        while (!Load && waited < 200) begin
            @(posedge Clock);
            #1;
            waited++;
        end
        if (!Load) fail("load_timeout");
    endtask

    initial begin
        logic [3:0] n;
        Reset      = 1'b1;
        Cmd_valid  = 1'b1;
        Cmd_data   = 8'hFF;
        Cmd_select = 3'd7;
        Cmd_steps  = 4'd5;
`ifdef SEQ_ABORT_EN
        abort_in   = 1'b0;
`endif
        stall_seen = 1'b0;
        peak_count = 0;
        repeat (2) @(posedge Clock);
        #1;
        Reset     = 1'b0;
        Cmd_valid = 1'b0;
        @(negedge Clock);
        check("reset_count", Fifo_count, 0);
        check("reset_ready", Cmd_ready, 1);
        check("reset_load", Load, 0);
        check("reset_done", Done, 0);
        @(posedge Clock);
        #1;

        push_cmd(8'h14, 3'd3, 4'd3, 3);
        drain();
        push_cmd(8'hA5, 3'd5, 4'd0, 0);
        drain();

        // Long first command stalls the FSM so the FIFO fills and back-pressures.
        push_cmd(8'h31, 3'd1, 4'd15, 15);
        for (int i = 0; i < 5; i++) push_cmd(8'h40 + 8'(i), 3'(i), 4'(i), i);
        check("fifo_full_stall", stall_seen, 1);
        check("peak_count", peak_count, DEPTH);
        drain();

        // Reset in mid-SHIFT with two entries buffered discards everything.
        push_cmd(8'h77, 3'd2, 4'd15, 15);
        push_cmd(8'h88, 3'd3, 4'd2, 2);
        push_cmd(8'h99, 3'd4, 4'd2, 2);
        wait_load();
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("mid_reset_count", Fifo_count, 0);
        check("mid_reset_load", Load, 0);
        @(posedge Clock);
        #1;
        push_cmd(8'h5A, 3'd6, 4'd1, 1);
        drain();

`ifdef SEQ_ABORT_EN
        // Abort in the third SHIFT cycle: Done follows next cycle, then the buffered command runs.
        push_cmd(8'hC3, 3'd2, 4'd10, 3);
        push_cmd(8'h3C, 3'd5, 4'd2, 2);
        wait_load();
        repeat (3) @(posedge Clock);
        #1;
        abort_in = 1'b1;
        @(posedge Clock);
        #1;
        abort_in = 1'b0;
        drain();
`endif

        for (int i = 0; i < 120; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge Clock);
                #1;
            end
            n = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            push_cmd(8'($urandom), 3'($urandom), n, int'(n));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout (t=%0t)", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/barrel_cmd_sequencer.md
Name: barrel_cmd_sequencer

Overview:
Upstream control stage for the barrel rotator. It accepts rotate commands (data word, select code, step count) over a valid/ready handshake and buffers them in a small FIFO. It then drives the rotator's Load, Select and Data_in inputs cycle by cycle: one load cycle followed by N shift cycles. It reports completion so a consumer can sample the rotator output.

Parameters:
DATA_SIZE, 8, width of data word (matches rotator data_size)
SEL_W, 3, width of rotator Select code
CNT_W, 4, width of per-command step count
FIFO_DEPTH, 4, command FIFO entries; power of 2, >=2

Ports:
Clock  input  1  single clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
Cmd_valid  input  1  command present
Cmd_ready  output  1  FIFO can accept; equals !full
Cmd_data  input  DATA_SIZE  word to load into rotator
Cmd_select  input  SEL_W  Select code held for the whole command
Cmd_steps  input  CNT_W  number of shift cycles after load (0..2^CNT_W-1)
Load  output  1  to rotator Load
Select  output  SEL_W  to rotator Select
Data_out  output  DATA_SIZE  to rotator Data_in
Busy  output  1  command in progress (LOAD/SHIFT/DONE)
Done  output  1  one-cycle pulse; rotator output valid this cycle
Fifo_count  output  clog2(FIFO_DEPTH)+1  entries currently buffered

Behaviour:
- Reset (sync, high) clears FIFO pointers and count, forces state IDLE, and zeroes Load, Select, Data_out, Busy and Done. Cmd_ready=1 from the first cycle after reset deasserts. Reset mid-command discards the command and all buffered entries.
- Push: on posedge with Cmd_valid && Cmd_ready, write {Cmd_data, Cmd_select, Cmd_steps}. Cmd_ready = (Fifo_count != FIFO_DEPTH) and is combinational from the count. Cmd_valid while full is ignored; the source must hold its command.
- Pop: only in IDLE when Fifo_count != 0. The popped entry is latched into a command register.
- Simultaneous push and pop in one cycle: count unchanged; both take effect. Pointers wrap modulo FIFO_DEPTH.
- Full+pop: Cmd_ready is low during that cycle (registered count). The push is accepted next cycle.
- FSM, all outputs registered:
  - IDLE: Load=0, Busy=0. If FIFO non-empty: pop, go to LOAD.
  - LOAD (1 cycle): Load=1, Data_out=cmd data, Select=cmd select, Busy=1, step counter <= cmd steps. If steps==0 go to DONE, else go to SHIFT.
  - SHIFT: Load=0, Select and Data_out held, counter decrements each cycle. Go to DONE in the cycle the counter reaches 1, so there are exactly `steps` SHIFT cycles.
  - DONE (1 cycle): Done=1, Load=0, Busy=1. Go to IDLE.
- Latency: the pop cycle is followed by LOAD, then `steps` SHIFT cycles, then DONE. A command occupies steps+3 cycles including IDLE. The minimum back-to-back spacing between LOAD pulses is steps+3 cycles.
- Select and Data_out keep their last values in IDLE; they do not return to 0.
- Done never asserts while Load=1.

Optional Feature:
Macro SEQ_ABORT_EN.
- Defined: adds input port Abort (1 bit). Abort=1 in LOAD or SHIFT forces DONE on the next cycle; Done pulses with the partial result. Abort in IDLE or DONE is ignored. FIFO contents are kept.
- Undefined: no Abort port; commands always run to completion.

Test Plan:
- Reset held 2 cycles with Cmd_valid=1 -> no push, Fifo_count=0, Load=0, Done=0. Cmd_ready=1 after release.
- Single command data=8'h14, select=3, steps=3 -> Load=1 for one cycle with Data_out=8'h14 and Select=3, then 3 cycles Load=0, then Done=1 for one cycle. Busy high for 5 cycles.
- Command with steps=0, data=8'hA5 -> Load cycle immediately followed by Done; no SHIFT cycles.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and the FSM stalled by a long first command (steps=15) -> Cmd_ready drops when Fifo_count=4. The 5th command is accepted after the first pop. All 5 Done pulses occur in push order with matching Data_out values.
- Push on the same cycle as an IDLE pop with count=2 -> count stays 2 and the next command loads correctly.
- Reset asserted during SHIFT with 2 entries buffered -> next cycle state IDLE, Fifo_count=0, Load=0, no Done pulse. With SEQ_ABORT_EN, Abort during SHIFT -> Done on the following cycle and the next buffered command loads afterward.
